// File: rtl/snake_pkg.sv
// Shared snake-game definitions.
// Holds the direction encoding used by the keypad scanner, the LED driver and
// the game FSM. Also holds the keypad key indices (4*row+col) that carry
// commands, and small helpers that map a key to its command.
package snake_pkg;

    typedef logic [1:0] dir_t;

    // Bit 1 selects the axis (0 = vertical, 1 = horizontal).
    // Bit 0 selects the sense along that axis.
    localparam dir_t DIR_UP    = 2'b00;
    localparam dir_t DIR_DOWN  = 2'b01;
    localparam dir_t DIR_LEFT  = 2'b10;
    localparam dir_t DIR_RIGHT = 2'b11;

    localparam logic [3:0] KEY_UP    = 4'd1;
    localparam logic [3:0] KEY_LEFT  = 4'd4;
    localparam logic [3:0] KEY_START = 4'd5;
    localparam logic [3:0] KEY_RIGHT = 4'd6;
    localparam logic [3:0] KEY_DOWN  = 4'd9;

    typedef struct packed {
        logic is_dir;
        dir_t dir;
        logic is_start;
    } key_cmd_t;

    // Index of the lowest set bit; 0 when no bit is set.
    function automatic logic [3:0] lowest_key(input logic [15:0] keys);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (keys[i]) idx = 4'(i);
        end
        return idx;
    endfunction

    function automatic key_cmd_t decode_key(input logic [3:0] key);
        key_cmd_t cmd;
        cmd = '{is_dir: 1'b0, dir: DIR_UP, is_start: 1'b0};
        case (key)
            KEY_UP:    begin cmd.is_dir = 1'b1; cmd.dir = DIR_UP;    end
            KEY_DOWN:  begin cmd.is_dir = 1'b1; cmd.dir = DIR_DOWN;  end
            KEY_LEFT:  begin cmd.is_dir = 1'b1; cmd.dir = DIR_LEFT;  end
            KEY_RIGHT: begin cmd.is_dir = 1'b1; cmd.dir = DIR_RIGHT; end
            KEY_START: cmd.is_start = 1'b1;
            default:   ;
        endcase
        return cmd;
    endfunction

    // A turn is legal only onto the other axis. This blocks both a 180-degree
    // reversal and a repeat of the current direction.
    function automatic logic dir_allowed(input dir_t cur, input dir_t cand);
        return (cand != cur) && (cand[1] != cur[1]);
    endfunction

endpackage

// File: rtl/frame_debounce.sv
// Whole-frame debouncer.
// The stable state takes a new frame value only after that value has repeated
// on consecutive frames. A differing frame restarts the count.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   raw         - most recent complete frame of key states
//   frame_done  - one-cycle strobe, raw holds a complete new frame
//   stable      - debounced key state
module frame_debounce #(
    parameter int WIDTH          = 16,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] raw,
    input  logic             frame_done,
    output logic [WIDTH-1:0] stable
);

    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);

    logic [WIDTH-1:0] prev_raw;
    logic [CNT_W-1:0] stab_cnt;
    logic             same;

    assign same = (raw == prev_raw);

    // NOTE: sequential state uses non-blocking assignments only. Every register
    // then samples pre-edge values, whatever order the statements are in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_raw <= '0;
            stab_cnt <= '0;
            stable   <= '0;
        end else if (frame_done) begin
            prev_raw <= raw;
            if (same) begin
                // The counter saturates so that a long hold never wraps round
                // into a second update.
                if (stab_cnt != CNT_W'(DEBOUNCE_SCANS))
                    stab_cnt <= stab_cnt + 1'b1;
                if (stab_cnt == CNT_W'(DEBOUNCE_SCANS - 1))
                    stable <= raw;
            end else begin
                stab_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/keypad_dir_scanner.sv
// 4x4 membrane keypad scanner with snake direction and start commands.
// Drives one row low at a time and samples the active-low columns at the end
// of each row dwell. Full frames are debounced. Each new press reports its
// lowest-index key as a one-cycle event, which is then mapped to a direction
// or start command.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   col_in[3:0]  - keypad columns, active-low (pulled up)
//   row_out[3:0] - keypad row drive, active-low, one row at a time
//   key_valid    - one-cycle pulse on a newly pressed key
//   key_code     - 4*row+col of the last reported key
//   key_held     - any key set in the debounced state
//   dir          - accepted direction (UP/DOWN/LEFT/RIGHT = 00/01/10/11)
//   dir_valid    - one-cycle pulse when dir changes
//   start_pulse  - one-cycle pulse on a new press of the start key
module keypad_dir_scanner
    import snake_pkg::*;
#(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] col_in,
    output logic [3:0] row_out,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic       key_held,
    output logic [1:0] dir,
    output logic       dir_valid,
    output logic       start_pulse
);

    localparam int DIV_W = $clog2(SCAN_DIV);

    logic [DIV_W-1:0] div_cnt;
    logic [1:0]       row_idx;
    logic             div_wrap;
    logic [15:0]      raw;
    logic             frame_done;
    logic [15:0]      stable;
    logic [15:0]      stable_d;

    logic [15:0]      new_press;
    logic             any_press;
    logic [3:0]       press_key;
    key_cmd_t         press_cmd;
    logic             dir_accept;

    // ---------------- Row scan and column sampling ----------------
    assign div_wrap = (div_cnt == DIV_W'(SCAN_DIV - 1));
    assign row_out  = ~(4'b0001 << row_idx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt    <= '0;
            row_idx    <= 2'd0;
            raw        <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (div_wrap) begin
                div_cnt <= '0;
                row_idx <= row_idx + 2'd1;
                // Columns are sampled on the last dwell cycle. The cycles
                // before it let the row line settle after switching.
                raw[{row_idx, 2'b00} +: 4] <= ~col_in;
                frame_done                 <= (row_idx == 2'd3);
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

    // ---------------- Debounce ----------------
    frame_debounce #(
        .WIDTH          (16),
        .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
    ) u_debounce (
        .clk        (clk),
        .rst_n      (rst_n),
        .raw        (raw),
        .frame_done (frame_done),
        .stable     (stable)
    );

    // ---------------- Press detection and command map ----------------
    // NOTE: each always_comb output is assigned on every path (here
    // unconditionally), so no latch can be inferred.
    always_comb begin
        new_press  = stable & ~stable_d;
        any_press  = |new_press;
        // Only the lowest new key is reported. Others that land in the same
        // frame are dropped and are not queued.
        press_key  = lowest_key(new_press);
        press_cmd  = decode_key(press_key);
        dir_accept = any_press && press_cmd.is_dir && dir_allowed(dir, press_cmd.dir);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_d    <= '0;
            key_valid   <= 1'b0;
            key_code    <= 4'd0;
            key_held    <= 1'b0;
            dir         <= DIR_RIGHT;
            dir_valid   <= 1'b0;
            start_pulse <= 1'b0;
        end else begin
            stable_d    <= stable;
            key_held    <= |stable;
            key_valid   <= any_press;
            start_pulse <= any_press && press_cmd.is_start;
            dir_valid   <= dir_accept;
            if (any_press)
                key_code <= press_key;
            if (dir_accept)
                dir <= press_cmd.dir;
        end
    end

endmodule

// File: tb/tb_keypad_dir_scanner.sv
// Self-checking bench for keypad_dir_scanner (SCAN_DIV=4, DEBOUNCE_SCANS=2).
// A keypad model pulls a column low only while the row of a pressed key is
// driven. Key sets change only on frame boundaries. A frame-level reference
// model predicts the debounced state and the reported events: a new stable
// state needs DEBOUNCE_SCANS+1 identical frames in a row, and each event
// appears on the third cycle of the following frame.
module tb_keypad_dir_scanner;

    localparam int SCAN_DIV       = 4;
    localparam int DEBOUNCE_SCANS = 2;
    localparam int FRAME          = 4 * SCAN_DIV;

    logic       clk;
    logic       rst_n;
    logic [3:0] col_in;
    logic [3:0] row_out;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_held;
    logic [1:0] dir;
    logic       dir_valid;
    logic       start_pulse;

    logic [15:0] pressed;

    keypad_dir_scanner #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .col_in      (col_in),
        .row_out     (row_out),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .key_held    (key_held),
        .dir         (dir),
        .dir_valid   (dir_valid),
        .start_pulse (start_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Passive keypad. Columns are pulled up, and a pressed key shorts its
    // column to a driven (low) row.
    always_comb begin
        col_in = 4'hF;
        for (int r = 0; r < 4; r++) begin
            if (!row_out[r]) col_in = col_in & ~pressed[4*r +: 4];
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- Reference model ----------------
    typedef struct packed {
        logic       kv;
        logic       dv;
        logic       sp;
        logic [3:0] code;
        logic [1:0] dir;
        logic       held;
    } obs_t;

    logic [15:0] hist[$];
    logic [15:0] m_stable;
    logic [1:0]  m_dir;
    logic [3:0]  m_code;
    obs_t        pend;
    obs_t        vis;

    task automatic model_reset();
        hist.delete();
        hist.push_back(16'h0);
        m_stable = 16'h0;
        m_dir    = 2'b11;
        m_code   = 4'd0;
        pend     = '{kv: 1'b0, dv: 1'b0, sp: 1'b0, code: 4'd0, dir: 2'b11, held: 1'b0};
        vis      = pend;
    endtask

    // Feeds one whole frame of key states into the model and returns what
    // the outputs will show once that frame's events have come out.
    task automatic model_frame(input logic [15:0] keys, output obs_t o);
        logic [15:0] new_st;
        logic [15:0] newp;
        logic        all_same;
        logic        is_dir;
        logic [1:0]  cand;
        int          key;
        hist.push_back(keys);
        if (hist.size() > DEBOUNCE_SCANS + 1) void'(hist.pop_front());
        all_same = (hist.size() == DEBOUNCE_SCANS + 1);
        foreach (hist[k]) if (hist[k] != keys) all_same = 1'b0;
        new_st   = all_same ? keys : m_stable;
        newp     = new_st & ~m_stable;
        m_stable = new_st;
        o = '{kv: 1'b0, dv: 1'b0, sp: 1'b0, code: 4'd0, dir: 2'b00, held: 1'b0};
        if (newp != 16'h0) begin
            key = 0;
            while (!newp[key]) key++;
            o.kv   = 1'b1;
            m_code = 4'(key);
            o.sp   = (key == 5);
            is_dir = 1'b1;
            cand   = 2'b00;
            case (key)
                1:       cand = 2'b00;
                9:       cand = 2'b01;
                4:       cand = 2'b10;
                6:       cand = 2'b11;
                default: is_dir = 1'b0;
            endcase
            // A turn must change axis (bit 1) and land on a new direction.
            if (is_dir && cand != m_dir && cand[1] != m_dir[1]) begin
                o.dv  = 1'b1;
                m_dir = cand;
            end
        end
        o.code = m_code;
        o.dir  = m_dir;
        o.held = |m_stable;
    endtask

    // Runs one frame with a fixed key set and checks every cycle of it.
    // Called and returns on a falling edge at the start of a frame.
    task automatic run_frame(input logic [15:0] keys);
        obs_t       nxt;
        logic [2:0] exp_pulses;
        logic [3:0] exp_row;
        pressed = keys;
        model_frame(keys, nxt);
        for (int i = 0; i < FRAME; i++) begin
            exp_pulses = 3'b000;
            if (i == 2) begin
                exp_pulses = {pend.kv, pend.dv, pend.sp};
                vis        = pend;
            end
            exp_row = 4'b0001 << (i / SCAN_DIV);
            exp_row = ~exp_row;
            check("row_out", {28'h0, row_out}, {28'h0, exp_row});
            check("pulses kv/dv/sp", {29'h0, key_valid, dir_valid, start_pulse}, {29'h0, exp_pulses});
            if (i == FRAME / 2) begin
                check("key_code", {28'h0, key_code}, {28'h0, vis.code});
                check("dir",      {30'h0, dir},      {30'h0, vis.dir});
                check("key_held", {31'h0, key_held}, {31'h0, vis.held});
            end
            @(negedge clk);
        end
        pend = nxt;
    endtask

    task automatic run_frames(input logic [15:0] keys, input int n);
        for (int k = 0; k < n; k++) run_frame(keys);
    endtask

    // Asserted and released on a falling edge; the key set is left as is.
    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        check("rst row_out",     {28'h0, row_out}, 32'he);
        check("rst dir",         {30'h0, dir},     32'h3);
        check("rst key_code",    {28'h0, key_code}, 32'h0);
        check("rst key_held",    {31'h0, key_held}, 32'h0);
        check("rst pulses",      {29'h0, key_valid, dir_valid, start_pulse}, 32'h0);
        repeat (2) @(negedge clk);
        check("rst hold row_out", {28'h0, row_out}, 32'he);
        model_reset();
        rst_n = 1'b1;
    endtask

    function automatic logic [15:0] bit_of(input int k);
        logic [15:0] one;
        one = 16'h1;
        return one << k;
    endfunction

    function automatic int pick_key();
        int sel;
        sel = int'($urandom_range(0, 6));
        case (sel)
            0: return 1;
            1: return 4;
            2: return 5;
            3: return 6;
            4: return 9;
            default: return int'($urandom_range(0, 15));
        endcase
    endfunction

    logic [15:0] cur;

    initial begin
        rst_n   = 1'b0;
        pressed = 16'h0;
        model_reset();
        @(negedge clk);

        // Reset values, then the row rotation and a clean press of UP.
        apply_reset();
        run_frames(16'h0, 2);
        run_frames(bit_of(1), 5);
        run_frames(16'h0, 4);

        // Reversal from RIGHT is rejected; the perpendicular DOWN is accepted.
        apply_reset();
        run_frames(16'h0, 1);
        run_frames(bit_of(4), 4);
        run_frames(16'h0, 4);
        run_frames(bit_of(9), 4);
        run_frames(16'h0, 4);

        // Bounce faster than the debounce window, then a steady hold.
        for (int k = 0; k < 6; k++) run_frame((k % 2 == 0) ? bit_of(6) : 16'h0);
        run_frames(bit_of(6), 4);
        run_frames(16'h0, 4);

        // Simultaneous start and DOWN: only the lower index is reported.
        run_frames(bit_of(5) | bit_of(9), 4);
        run_frames(16'h0, 4);

        // Reset while start is held: it is debounced and reported again.
        run_frames(bit_of(5), 4);
        apply_reset();
        run_frames(bit_of(5), 5);
        run_frames(16'h0, 4);

        // Random key traffic, biased towards the command keys, with holds
        // long enough to debounce and bursts short enough to be rejected.
        cur = 16'h0;
        for (int k = 0; k < 70; k++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: ;
                6, 7: cur = 16'h0;
                default: begin
                    cur = bit_of(pick_key());
                    if ($urandom_range(0, 3) == 0) cur = cur | bit_of(pick_key());
                end
            endcase
            run_frame(cur);
        end
        run_frames(16'h0, 4);

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule
